// File: rtl/basilisk_writeback_arbiter_pkg.sv
// Shared types for the FP writeback arbiter: the result payload carried to the
// register file and the index type that names which execution unit produced it.
package basilisk_writeback_arbiter_pkg;

  localparam int BASILISK_WRITEBACK_SOURCES = 4;
  localparam int BASILISK_REG_ADDR_W        = 5;
  localparam int BASILISK_RESULT_W          = 64;

  typedef logic [$clog2(BASILISK_WRITEBACK_SOURCES)-1:0] basilisk_src_t;

  typedef struct packed {
    logic [BASILISK_REG_ADDR_W-1:0] dest_reg_addr;
    logic [BASILISK_RESULT_W-1:0]   result;
  } basilisk_result_t;

endpackage

// File: rtl/basilisk_writeback_arbiter_if.sv
// Valid/ready result stream; the producer side uses master, the consumer side slave.
interface std_stream_intf;
  import basilisk_writeback_arbiter_pkg::*;

  logic             valid;
  logic             ready;
  basilisk_result_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/basilisk_writeback_arbiter_flow_stage.sv
// One-entry flow-through stage: MODE=1 registers the data, MODE=0 is a wire.
// The registered form accepts while it is empty or being drained in the same cycle.
module std_flow_stage
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int MODE  = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  if (MODE == 1) begin : g_reg
    logic             full;
    logic [WIDTH-1:0] data;

    assign up_ready = !full || dn_ready;
    assign dn_valid = full;
    assign dn_data  = data;

    always_ff @(posedge clk) begin
      if (rst) begin
        full <= 1'b0;
        data <= '0;
      end else if (up_ready) begin
        full <= up_valid;
        if (up_valid) data <= up_data;
      end
    end
  end else begin : g_pass
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign up_ready       = dn_ready;
    assign dn_valid       = up_valid;
    assign dn_data        = up_data;
  end

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// Round-robin arbiter that merges the FP execution-unit result streams onto the
// single register-file write port, with an optional registered output stage.
module basilisk_writeback_arbiter
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS           = BASILISK_WRITEBACK_SOURCES,
  parameter int OUTPUT_REGISTER_MODE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  std_stream_intf.slave                 result_in [NUM_INPUTS],
  std_stream_intf.master                result_out,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_source
);

  localparam int SRC_W   = $clog2(NUM_INPUTS);
  localparam int STAGE_W = SRC_W + $bits(basilisk_result_t);

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] ready_vec;
  basilisk_result_t      payloads [NUM_INPUTS];
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      winner;
  logic                  found;
  logic                  up_valid;
  logic                  stage_ready;
  logic                  transfer;
  logic [STAGE_W-1:0]    stage_in;
  logic [STAGE_W-1:0]    stage_out;
  int                    cand;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
    assign req[g]             = result_in[g].valid;
    assign payloads[g]        = result_in[g].payload;
    assign result_in[g].ready = ready_vec[g];
  end

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      if (!found && req[SRC_W'(cand)]) begin
        found  = 1'b1;
        winner = SRC_W'(cand);
      end
    end
  end

  assign up_valid = found && !rst;
  assign transfer = up_valid && stage_ready;
  assign stage_in = up_valid ? {winner, payloads[winner]} : '0;

  always_comb begin
    ready_vec = '0;
    if (transfer) ready_vec[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_W'(NUM_INPUTS - 1);
    end else if (transfer) begin
      last_grant <= winner;
    end
  end

  std_flow_stage #(
    .MODE  (OUTPUT_REGISTER_MODE),
    .WIDTH (STAGE_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .up_valid (up_valid),
    .up_ready (stage_ready),
    .up_data  (stage_in),
    .dn_valid (result_out.valid),
    .dn_ready (result_out.ready),
    .dn_data  (stage_out)
  );

  assign {grant_source, result_out.payload} = stage_out;

endmodule

// File: tb/tb_basilisk_writeback_arbiter.sv
// Drives a registered and a pass-through arbiter side by side and checks both
// against a queue-based round-robin model plus hand-computed directed scenarios.
module tb_basilisk_writeback_arbiter;
  import basilisk_writeback_arbiter_pkg::*;

  localparam int NI            = 4;
  localparam int RANDOM_CYCLES = 10000;
  localparam int QUEUE_LIMIT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_next = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]    vld [2] = '{default: '0};
  basilisk_result_t pay [2][NI];
  logic             ordy [2] = '{1'b1, 1'b1};
  logic             ordy_next [2] = '{1'b1, 1'b1};

  logic [NI-1:0]    rdy_w [2];
  logic             ov_w [2];
  basilisk_result_t opay_w [2];
  logic [1:0]       grant_w [2];

  for (genvar m = 0; m < 2; m++) begin : g_mode
    std_stream_intf in_if [NI] ();
    std_stream_intf out_if ();
    logic [1:0] grant;

    for (genvar i = 0; i < NI; i++) begin : g_in
      assign in_if[i].valid   = vld[m][i];
      assign in_if[i].payload = pay[m][i];
    end
    assign out_if.ready = ordy[m];
    assign rdy_w[m]     = {in_if[3].ready, in_if[2].ready, in_if[1].ready, in_if[0].ready};
    assign ov_w[m]      = out_if.valid;
    assign opay_w[m]    = out_if.payload;
    assign grant_w[m]   = grant;

    basilisk_writeback_arbiter #(
      .NUM_INPUTS           (NI),
      .OUTPUT_REGISTER_MODE (m)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .result_in    (in_if),
      .result_out   (out_if),
      .grant_source (grant)
    );
  end

  // Producer side: each input has a queue of results waiting to be offered.
  basilisk_result_t pend [2][NI][$];
  logic             presenting [2][NI] = '{default: '0};
  int               gen_cnt [2][NI] = '{default: 0};
  logic             gate_all = 1'b1;
  logic             sb_en = 1'b0;
  logic             end_chk = 1'b0;

  logic       lit_rdy_en = 1'b0, lit_ov_en = 1'b0, lit_grant_en = 1'b0, lit_dest_en = 1'b0;
  logic [3:0] lit_rdy = '0;
  logic       lit_ov = 1'b0;
  logic [1:0] lit_grant = '0;
  logic [4:0] lit_dest = '0;

  // Reference model state, owned by the compare process.
  int               ml_last [2] = '{NI - 1, NI - 1};
  logic             slot_full [2] = '{1'b0, 1'b0};
  basilisk_result_t slot [2];
  int               slot_src [2] = '{0, 0};
  int               sb_next [2][NI] = '{default: 0};
  int               waitc [2][NI] = '{default: 0};
  logic             acc [2][NI] = '{default: '0};
  int               w, c, s, egrant;
  logic [NI-1:0]    erdy;
  logic             eov;
  basilisk_result_t epay;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // One model step per cycle, evaluated after the inputs for the cycle settle.
  always @(negedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      w = -1;
      erdy = '0;
      eov = 1'b0;
      epay = '0;
      egrant = 0;
      if (!rst) begin
        for (int k = 1; k <= NI; k++) begin
          c = (ml_last[m] + k) % NI;
          if (w < 0 && vld[m][c]) w = c;
        end
      end
      if (m == 1) begin
        eov = slot_full[1];
        epay = slot[1];
        egrant = slot_src[1];
        if (w >= 0 && (!slot_full[1] || ordy[1])) erdy[w] = 1'b1;
      end else if (w >= 0) begin
        eov = 1'b1;
        epay = pay[0][w];
        egrant = w;
        if (ordy[0]) erdy[w] = 1'b1;
      end

      checkOutput($sformatf("mode%0d ready", m), rdy_w[m], erdy);
      checkOutput($sformatf("mode%0d out_valid", m), ov_w[m], eov);
      if (eov) begin
        checkOutput($sformatf("mode%0d payload", m), opay_w[m], epay);
        checkOutput($sformatf("mode%0d grant_source", m), grant_w[m], egrant);
      end

      if (!rst && ov_w[m] && ordy[m]) begin
        s = int'(opay_w[m].result[23:16]);
        if (sb_en) checkOutput($sformatf("mode%0d source tag", m), grant_w[m], s);
        if (s < NI) begin
          if (sb_en) checkOutput($sformatf("mode%0d order src%0d", m, s), opay_w[m].result[15:0], sb_next[m][s]);
          sb_next[m][s]++;
        end
      end

      for (int i = 0; i < NI; i++) acc[m][i] = 1'b0;
      if (rst) begin
        ml_last[m] = NI - 1;
        slot_full[m] = 1'b0;
        for (int i = 0; i < NI; i++) begin
          waitc[m][i] = 0;
          sb_next[m][i] = 0;
        end
      end else begin
        if (slot_full[m] && ordy[m]) slot_full[m] = 1'b0;
        if (erdy != '0) begin
          for (int i = 0; i < NI; i++) begin
            if (i == w) begin
              if (sb_en) checkOutput($sformatf("mode%0d starvation src%0d", m, i), waitc[m][i] < NI, 1);
              waitc[m][i] = 0;
            end else if (vld[m][i]) begin
              waitc[m][i]++;
            end
          end
          acc[m][w] = 1'b1;
          ml_last[m] = w;
          if (m == 1) begin
            slot_full[1] = 1'b1;
            slot[1] = pay[1][w];
            slot_src[1] = w;
          end
        end
      end
    end

    if (lit_rdy_en)   checkOutput("lit ready", rdy_w[1], lit_rdy);
    if (lit_ov_en)    checkOutput("lit out_valid", ov_w[1], lit_ov);
    if (lit_grant_en) checkOutput("lit grant_source", grant_w[1], lit_grant);
    if (lit_dest_en)  checkOutput("lit dest_reg_addr", opay_w[1].dest_reg_addr, lit_dest);
    if (end_chk) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < NI; i++)
          checkOutput($sformatf("mode%0d delivered src%0d", m, i), sb_next[m][i], gen_cnt[m][i]);
    end
  end

  task automatic applyStimulus(input int m, input int i, input logic [4:0] dest);
    basilisk_result_t it;
    it.dest_reg_addr = dest;
    it.result = {8'($urandom), 32'($urandom), 8'(i), 16'(gen_cnt[m][i])};
    pend[m][i].push_back(it);
    gen_cnt[m][i]++;
  endtask

  task automatic tick();
    @(negedge clk);
    rst = rst_next;
    lit_rdy_en = 1'b0;
    lit_ov_en = 1'b0;
    lit_grant_en = 1'b0;
    lit_dest_en = 1'b0;
    end_chk = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ordy[m] = ordy_next[m];
      for (int i = 0; i < NI; i++) begin
        if (rst_next) begin
          pend[m][i].delete();
          presenting[m][i] = 1'b0;
          gen_cnt[m][i] = 0;
        end else begin
          if (presenting[m][i] && acc[m][i]) begin
            void'(pend[m][i].pop_front());
            presenting[m][i] = 1'b0;
          end
          if (!presenting[m][i] && pend[m][i].size() > 0 && (gate_all || $urandom_range(99) < 70))
            presenting[m][i] = 1'b1;
        end
        vld[m][i] = presenting[m][i];
        if (presenting[m][i]) pay[m][i] = pend[m][i][0];
      end
    end
  endtask

  task automatic doReset();
    rst_next = 1'b1;
    tick();
    tick();
    lit_ov_en = 1'b1;    lit_ov = 1'b0;
    lit_grant_en = 1'b1; lit_grant = 2'd0;
    lit_rdy_en = 1'b1;   lit_rdy = 4'b0000;
    rst_next = 1'b0;
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
  int idle;

  initial begin
    // Lone requester on input 2 right after reset.
    doReset();
    applyStimulus(1, 2, 5'd5);
    tick(); lit_rdy_en = 1; lit_rdy = 4'b0100;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 2; lit_dest_en = 1; lit_dest = 5'd5;

    // Everyone requesting with the sink always ready.
    doReset();
    for (int i = 0; i < NI; i++)
      for (int r = 0; r < 3; r++) applyStimulus(1, i, 5'($urandom));
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      lit_ov_en = 1; lit_ov = 1;
      lit_grant_en = 1; lit_grant = 2'(exp_seq[k]);
    end

    // Sink stalls for five cycles, then resumes.
    doReset();
    ordy_next[1] = 1'b0;
    for (int i = 0; i < NI; i++)
      for (int r = 0; r < 2; r++) applyStimulus(1, i, 5'($urandom));
    tick(); lit_rdy_en = 1; lit_rdy = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 0; lit_rdy_en = 1; lit_rdy = 4'b0000;
    end
    ordy_next[1] = 1'b1;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 0; lit_rdy_en = 1; lit_rdy = 4'b0010;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 1;

    // Inputs 1 and 3 competing after input 1 was the last winner.
    doReset();
    applyStimulus(1, 1, 5'd1);
    tick(); lit_rdy_en = 1; lit_rdy = 4'b0010;
    applyStimulus(1, 1, 5'd2);
    applyStimulus(1, 3, 5'd3);
    tick(); lit_rdy_en = 1; lit_rdy = 4'b1000; lit_grant_en = 1; lit_grant = 1;
    tick(); lit_rdy_en = 1; lit_rdy = 4'b0010; lit_grant_en = 1; lit_grant = 3;
    tick(); lit_grant_en = 1; lit_grant = 1;

    // Reset while a result sits undelivered in the output register.
    doReset();
    ordy_next[1] = 1'b0;
    applyStimulus(1, 2, 5'd9);
    tick(); lit_rdy_en = 1; lit_rdy = 4'b0100;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 2; lit_rdy_en = 1; lit_rdy = 4'b0000;
    rst_next = 1'b1;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_rdy_en = 1; lit_rdy = 4'b0000;
    rst_next = 1'b0;
    ordy_next[1] = 1'b1;
    applyStimulus(1, 0, 5'd10);
    applyStimulus(1, 3, 5'd11);
    tick(); lit_ov_en = 1; lit_ov = 0; lit_rdy_en = 1; lit_rdy = 4'b0001;
    tick(); lit_ov_en = 1; lit_ov = 1; lit_grant_en = 1; lit_grant = 0;
    tick(); lit_grant_en = 1; lit_grant = 3;

    // Random traffic on both variants.
    doReset();
    sb_en = 1'b1;
    gate_all = 1'b0;
    for (int n = 0; n < RANDOM_CYCLES; n++) begin
      for (int m = 0; m < 2; m++) begin
        ordy_next[m] = ($urandom_range(99) < 70);
        for (int i = 0; i < NI; i++)
          if ($urandom_range(99) < 30 && pend[m][i].size() < QUEUE_LIMIT)
            applyStimulus(m, i, 5'($urandom));
      end
      tick();
    end

    ordy_next = '{1'b1, 1'b1};
    gate_all = 1'b1;
    for (int n = 0; n < 400; n++) begin
      tick();
      idle = 1;
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < NI; i++)
          if (pend[m][i].size() > 0) idle = 0;
      if (idle == 1) break;
    end
    repeat (4) tick();
    tick();
    end_chk = 1'b1;
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
